// File: rtl/unified_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_pkg
//   Shared definitions for the unified instruction/data memory arbiter:
//   FSM state and transaction-owner encodings, legal parameter ranges and
//   internal counter widths.
// -----------------------------------------------------------------------------
package unified_mem_arbiter_pkg;

   // Arbiter FSM: either free to grant, or waiting for a read to return.
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RD_WAIT = 1'b1
   } state_e;

   // Which requester owns the read currently in flight.
   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   // Legal ranges for the top-level parameters.
   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 4;
   localparam int BURST_MIN    = 1;
   localparam int BURST_MAX    = 15;

   // burst_cnt must hold BURST_MAX; lat_cnt must hold READ_LAT_MAX-1.
   localparam int BURST_CNT_W  = 4;
   localparam int LAT_CNT_W    = 2;

endpackage : unified_mem_arbiter_pkg

// File: rtl/unified_mem_arbiter_starve_guard.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_starve_guard
//   Bounds how long the data port can keep the fetch port off the memory.
//   Counts consecutive D grants taken while a fetch is waiting; once the count
//   reaches MAX_DATA_BURST and a fetch is still pending, force_if tells the
//   arbiter to hand the next slot to IF.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   synchronous reset, active-low
//   if_req    in   fetch request pending
//   if_gnt    in   fetch granted this cycle
//   d_gnt     in   data access granted this cycle
//   force_if  out  IF must win the next arbitration
// -----------------------------------------------------------------------------
module unified_mem_arbiter_starve_guard
   import unified_mem_arbiter_pkg::*;
#(
   parameter int MAX_DATA_BURST = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic if_gnt,
   input  logic d_gnt,
   output logic force_if
);

   localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_DATA_BURST);

   logic [BURST_CNT_W-1:0] burst_cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of process order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         burst_cnt <= '0;
      end else if (if_gnt) begin
         burst_cnt <= '0;
      end else if (d_gnt) begin
         if (!if_req) begin
            // Nobody was starved by this D access, so the streak ends.
            burst_cnt <= '0;
         end else if (burst_cnt != BURST_LIMIT) begin
            burst_cnt <= burst_cnt + 1'b1;
         end
      end
   end

   assign force_if = if_req && (burst_cnt == BURST_LIMIT);

endmodule : unified_mem_arbiter_starve_guard

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//   Shares a single-port unified instruction/data memory between the fetch
//   stage (IF) and the load/store stage (D). One transaction is in flight at a
//   time. D has priority, bounded by a starvation guard that periodically
//   forces an IF grant. Fetches already granted can be cancelled by if_flush:
//   the memory read still completes but its data is discarded.
//
//   Timing: grants and memory strobes are combinational in the grant cycle T.
//   A store completes in T and reports d_valid in T+1. A read reports its
//   valid READ_LAT+1 cycles after the grant; a new grant may share the cycle
//   of that valid pulse.
//
// Ports
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   if_req/if_addr              fetch request (level) and address
//   if_flush                    cancel a granted, unreturned fetch
//   if_gnt                      fetch accepted this cycle
//   if_valid/if_rdata           fetch response pulse and held data
//   d_req/d_we/d_addr/d_wdata   data request, store flag, address, store data
//   d_gnt                       data access accepted this cycle
//   d_valid/d_rdata             load data ready or store done; held load data
//   mem_en/mem_we               memory strobe and write enable
//   mem_addr/mem_wdata          memory address (winner) and write data
//   mem_rdata                   memory read data, READ_LAT cycles after mem_en
// -----------------------------------------------------------------------------
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int READ_LAT       = 1,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // fetch port
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   // data port
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   // memory macro
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // ---------------------------------------------------------------------------
   // Parameter legality, reported at elaboration
   // ---------------------------------------------------------------------------
   if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
      $error("unified_mem_arbiter: READ_LAT=%0d outside %0d..%0d",
             READ_LAT, READ_LAT_MIN, READ_LAT_MAX);
   end
   if (MAX_DATA_BURST < BURST_MIN || MAX_DATA_BURST > BURST_MAX) begin : g_bad_burst
      $error("unified_mem_arbiter: MAX_DATA_BURST=%0d outside %0d..%0d",
             MAX_DATA_BURST, BURST_MIN, BURST_MAX);
   end

   localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(READ_LAT - 1);

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   state_e               state;
   state_e               state_nxt;
   owner_e               owner;
   logic                 drop;      // current IF read has been flushed
   logic [LAT_CNT_W-1:0] lat_cnt;   // cycles left until mem_rdata is valid
   logic                 force_if;
   logic                 rd_grant;  // a read is launched this cycle
   logic                 rd_done;   // mem_rdata is valid this cycle

   // ---------------------------------------------------------------------------
   // Starvation guard
   // ---------------------------------------------------------------------------
   unified_mem_arbiter_starve_guard #(
      .MAX_DATA_BURST (MAX_DATA_BURST)
   ) u_arb_starve_guard (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req),
      .if_gnt   (if_gnt),
      .d_gnt    (d_gnt),
      .force_if (force_if)
   );

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (rd_grant) begin
               state_nxt = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (lat_cnt == '0) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs (arbitration and grants)
   // ---------------------------------------------------------------------------
   // Grants exist only in IDLE and are suppressed while reset is asserted.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (rst_n && state == ST_IDLE) begin
         if (d_req && !force_if) begin
            d_gnt = 1'b1;
         end else if (if_req) begin
            if_gnt = 1'b1;
         end
      end
   end

   assign mem_en    = if_gnt | d_gnt;
   assign mem_we    = d_gnt & d_we;
   assign mem_addr  = d_gnt ? d_addr : if_addr;
   assign mem_wdata = d_wdata;

   assign rd_grant  = mem_en & ~mem_we;
   assign rd_done   = (state == ST_RD_WAIT) && (lat_cnt == '0);

   // ---------------------------------------------------------------------------
   // Read bookkeeping: owner, latency countdown, flush tracking
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         owner   <= OWN_IF;
         lat_cnt <= '0;
         drop    <= 1'b0;
      end else if (rd_grant) begin
         owner   <= d_gnt ? OWN_D : OWN_IF;
         lat_cnt <= LAT_INIT;
         // A fetch granted while being flushed is already stale.
         drop    <= if_gnt & if_flush;
      end else if (state == ST_RD_WAIT) begin
         if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
         if (rd_done) begin
            drop <= 1'b0;
         end else if (owner == OWN_IF && if_flush) begin
            drop <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response registers
   // ---------------------------------------------------------------------------
   // Stores complete in the grant cycle and reads complete in RD_WAIT, so the
   // two valid sources never collide and the valids are mutually exclusive.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         if_rdata <= '0;
         d_rdata  <= '0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= d_gnt & d_we;
         if (rd_done) begin
            if (owner == OWN_D) begin
               d_rdata <= mem_rdata;
               d_valid <= 1'b1;
            end else if (!drop && !if_flush) begin
               // A flush in this final wait cycle still cancels the fetch.
               if_rdata <= mem_rdata;
               if_valid <= 1'b1;
            end
         end
      end
   end

endmodule : unified_mem_arbiter
